serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial multi-bit subtractor built around the half-subtractor cell: two half-subtractor stages plus one borrow flip-flop, processing one bit per clock, LSB first.
- Computes a - b - bin over WIDTH operand bits.
- Sits downstream of the combinational half-subtractor cell and replaces a ripple chain where area matters more than latency.
- Operands are captured on a start handshake; the result is presented with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand/result width in bits (minimum 1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when idle
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when diff/borrow_out are valid
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
- borrow_out  output  1  final borrow: 1 iff a < b + bin (unsigned)

Behaviour:
- Reset: on a rising edge with rst=1, all of the following clear to 0: busy, done, diff, borrow_out, the internal shift registers, the borrow flip-flop and the bit counter. State goes to IDLE. Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE and RUN.
- IDLE -> RUN:
  - Occurs on an edge where start=1.
  - That edge loads a and b into shift registers, loads bin into the borrow flip-flop, clears the counter, and sets busy=1.
  - diff and borrow_out keep their previous values until the operation completes.
- RUN, each edge, one bit:
  - d_i = a_i ^ b_i ^ br
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d_i shifts into diff from the MSB side. Operand registers shift right. Counter increments.
- RUN -> IDLE:
  - Occurs on the edge that processes bit WIDTH-1, i.e. the WIDTH-th RUN edge.
  - That edge sets busy=0 and done=1, makes diff hold the full result, and sets borrow_out to the final br'.
- Latency: done is high during the cycle exactly WIDTH clock edges after the edge that accepted start. Throughput is one operation per WIDTH cycles.
- done is high for exactly one cycle and deasserts on the next edge unless a new completion occurs.
- diff and borrow_out hold their values until the next completion or reset.
- start while busy=1 is ignored: no restart and no queueing.
- start high in the cycle where done=1 (state IDLE) is accepted. This gives back-to-back operation.
- start held high continuously causes a new operation to begin on every IDLE edge.
- diff is written only at completion. Partial results are never visible on the diff port: shift into an internal register and copy at the final edge.
- WIDTH=1: RUN lasts one edge; done is high 1 cycle after start is accepted.
- Arithmetic is unsigned modulo 2^WIDTH. For signed use, borrow_out is not an overflow flag.
- If rst and start are both high, rst wins.

Test Plan:
- WIDTH=8, a=100, b=37, bin=0, start pulsed 1 cycle -> busy high 8 cycles; done high exactly 8 edges after acceptance; diff=63, borrow_out=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, borrow_out=1. Also a=0x55, b=0x55, bin=1 -> diff=0xFF, borrow_out=1. Also a=0xFF, b=0x00, bin=1 -> diff=0xFE, borrow_out=0.
- Start a=10, b=3; pulse start again with a=1, b=2 at RUN cycle 3 -> second start ignored; done once; diff=7, borrow_out=0; busy low after completion.
- Assert rst at RUN cycle 4 -> next cycle busy=0, done=0, diff=0, borrow_out=0; no done pulse follows. Then start a=200, b=55 -> diff=145 after 8 cycles.
- Back-to-back: start held high for two operations (a=9,b=4 then a=4,b=9) -> done pulses 9 cycles apart; results 5/0 then 0xFB/1.
- WIDTH=1 instance, exhaustive over {a,b,bin} (8 cases) -> diff = a^b^bin, borrow_out = (~a&b)|(~(a^b)&bin), done 1 cycle after each start.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor.
//   master: drives start, a, b, bin; observes busy, done, diff, borrow_out
//   slave : the subtractor side (receives operands, returns status/result)
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, borrow_out
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, borrow_out
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin, one bit per clock, LSB first,
// using a two-stage half-subtractor datapath and a single borrow flop.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (aborts any operation in progress)
//   bus  - serial_subtractor_if slave: start/a/b/bin in,
//          busy/done/diff/borrow_out out
// A start seen in IDLE captures the operands; WIDTH edges later done pulses
// for one cycle with diff = (a - b - bin) mod 2^WIDTH and the final borrow.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   serial_subtractor_if.slave bus
);

   localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_e;

   state_e           state_q,  state_d;
   logic [WIDTH-1:0] a_sh_q,   a_sh_d;
   logic [WIDTH-1:0] b_sh_q,   b_sh_d;
   logic [WIDTH-1:0] acc_q,    acc_d;
   logic             br_q,     br_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
   logic [WIDTH-1:0] diff_q,   diff_d;
   logic             bout_q,   bout_d;

   // Datapath for the current bit
   logic             a_bit;
   logic             b_bit;
   logic             hs1_d;      // first half-subtractor difference
   logic             hs1_b;      // first half-subtractor borrow
   logic             d_bit;      // second stage: hs1_d - br
   logic             br_next;
   logic [WIDTH-1:0] acc_shift;

   always_comb begin
      a_bit   = a_sh_q[0];
      b_bit   = b_sh_q[0];
      hs1_d   = a_bit ^ b_bit;
      hs1_b   = ~a_bit & b_bit;
      d_bit   = hs1_d ^ br_q;
      br_next = hs1_b | (~hs1_d & br_q);

      // New bit enters at the MSB so after WIDTH shifts bit 0 sits at LSB
      acc_shift            = acc_q >> 1;
      acc_shift[WIDTH-1]   = d_bit;
   end

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      acc_d   = acc_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      diff_d  = diff_q;
      bout_d  = bout_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               br_d    = bus.bin;
               acc_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            acc_d  = acc_shift;
            br_d   = br_next;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // Result is published only here so diff never shows partials
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               diff_d  = acc_shift;
               bout_d  = br_next;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         acc_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         acc_q   <= acc_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.diff       = diff_q;
   assign bus.borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   typedef struct {
      logic [7:0] diff;
      logic       bo;
      longint     due;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Index 0: WIDTH=8 instance, index 1: WIDTH=1 instance
   int unsigned wid [2] = '{8, 1};

   logic       st [2];
   logic [7:0] av [2];
   logic [7:0] bv [2];
   logic       bn [2];
   logic       rs [2];

   logic       busy_o [2];
   logic       done_o [2];
   logic [7:0] diff_o [2];
   logic       bo_o   [2];

   serial_subtractor_if #(.WIDTH(8)) if8 ();
   serial_subtractor_if #(.WIDTH(1)) if1 ();

   serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rs[0]), .bus(if8));
   serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rs[1]), .bus(if1));

   assign if8.start = st[0];
   assign if8.a     = av[0];
   assign if8.b     = bv[0];
   assign if8.bin   = bn[0];
   assign if1.start = st[1];
   assign if1.a     = av[1][0];
   assign if1.b     = bv[1][0];
   assign if1.bin   = bn[1];

   assign busy_o[0] = if8.busy;
   assign done_o[0] = if8.done;
   assign diff_o[0] = if8.diff;
   assign bo_o[0]   = if8.borrow_out;
   assign busy_o[1] = if1.busy;
   assign done_o[1] = if1.done;
   assign diff_o[1] = {7'b0, if1.diff};
   assign bo_o[1]   = if1.borrow_out;

   exp_t        sb [2][$];
   longint      cyc = 0;
   int unsigned rem    [2] = '{0, 0};
   logic        mbusy  [2] = '{1'b0, 1'b0};
   logic [7:0]  hold_d [2] = '{8'h0, 8'h0};
   logic        hold_b [2] = '{1'b0, 1'b0};

   int nvec  = 0;
   int nfail = 0;

   task automatic chk(string nm, int i, logic [63:0] act, logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s inst=%0d cyc=%0d got=%0h expected=%0h", nm, i, cyc, act, exp);
      end
   endtask

   // Reference model: a timeline of accepted operations. An accepted start
   // occupies the unit for WIDTH edges; arithmetic done with plain integers.
   always @(posedge clk) begin
      int          r;
      int          m;
      exp_t        e;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (rs[i]) begin
            sb[i].delete();
            rem[i]    = 0;
            hold_d[i] = 8'h0;
            hold_b[i] = 1'b0;
         end else if (rem[i] != 0) begin
            rem[i]--;
         end else if (st[i]) begin
            m     = 1 << wid[i];
            r     = int'(av[i]) % m - int'(bv[i]) % m - int'(bn[i]);
            e.bo  = (r < 0);
            e.diff = 8'((r + m) % m);
            e.due = cyc + longint'(wid[i]);
            sb[i].push_back(e);
            rem[i] = wid[i];
         end
         mbusy[i] = (rem[i] != 0);
      end
   end

   // Monitor: compares outputs against the model after every edge
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("busy", i, 64'(busy_o[i]), 64'(mbusy[i]));
         if (done_o[i] === 1'b1) begin
            if (sb[i].size() == 0) begin
               chk("spurious_done", i, 64'd1, 64'd0);
            end else begin
               e = sb[i].pop_front();
               chk("done_time", i, 64'(cyc), 64'(e.due));
               hold_d[i] = e.diff;
               hold_b[i] = e.bo;
            end
         end else if (sb[i].size() > 0 && sb[i][0].due <= cyc) begin
            chk("done_missing", i, 64'd0, 64'd1);
            void'(sb[i].pop_front());
         end
         chk("diff",       i, 64'(diff_o[i]), 64'(hold_d[i]));
         chk("borrow_out", i, 64'(bo_o[i]),   64'(hold_b[i]));
      end
   end

   task automatic go(int i, logic s, logic [7:0] a, logic [7:0] b, logic c);
      st[i] = s;
      av[i] = a;
      bv[i] = b;
      bn[i] = c;
   endtask

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog inst=0 got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] va [3];
      logic [7:0] vb [3];
      logic       vc [3];
      va = '{8'h00, 8'h55, 8'hFF};
      vb = '{8'h01, 8'h55, 8'h00};
      vc = '{1'b0,  1'b1,  1'b1};

      for (int i = 0; i < 2; i++) begin
         go(i, 1'b0, 8'h0, 8'h0, 1'b0);
         rs[i] = 1'b1;
      end
      tick(2);
      rs[0] = 1'b0;
      rs[1] = 1'b0;
      tick(2);

      // 100 - 37
      go(0, 1'b1, 8'd100, 8'd37, 1'b0);
      tick(1);
      go(0, 1'b0, 8'd0, 8'd0, 1'b0);
      tick(10);

      // Wrap / borrow corners
      for (int k = 0; k < 3; k++) begin
         go(0, 1'b1, va[k], vb[k], vc[k]);
         tick(1);
         go(0, 1'b0, 8'd0, 8'd0, 1'b0);
         tick(9);
      end

      // Start during RUN is ignored
      go(0, 1'b1, 8'd10, 8'd3, 1'b0);
      tick(1);
      go(0, 1'b0, 8'd0, 8'd0, 1'b0);
      tick(2);
      go(0, 1'b1, 8'd1, 8'd2, 1'b0);
      tick(1);
      go(0, 1'b0, 8'd0, 8'd0, 1'b0);
      tick(8);

      // Reset mid-operation, then a fresh operation
      go(0, 1'b1, 8'd77, 8'd12, 1'b0);
      tick(1);
      go(0, 1'b0, 8'd0, 8'd0, 1'b0);
      tick(3);
      rs[0] = 1'b1;
      tick(1);
      rs[0] = 1'b0;
      tick(10);
      go(0, 1'b1, 8'd200, 8'd55, 1'b0);
      tick(1);
      go(0, 1'b0, 8'd0, 8'd0, 1'b0);
      tick(10);

      // Back-to-back with start held high
      go(0, 1'b1, 8'd9, 8'd4, 1'b0);
      tick(1);
      go(0, 1'b1, 8'd4, 8'd9, 1'b0);
      tick(9);
      go(0, 1'b0, 8'd0, 8'd0, 1'b0);
      tick(10);

      // WIDTH=1 exhaustive
      for (int k = 0; k < 8; k++) begin
         go(1, 1'b1, {7'b0, k[2]}, {7'b0, k[1]}, k[0]);
         tick(1);
         go(1, 1'b0, 8'd0, 8'd0, 1'b0);
         tick(2);
      end

      // Random traffic on both instances, including rare resets
      for (int n = 0; n < 500; n++) begin
         for (int i = 0; i < 2; i++) begin
            go(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            rs[i] = ($urandom_range(0, 63) == 0);
         end
         tick(1);
      end

      for (int i = 0; i < 2; i++) begin
         go(i, 1'b0, 8'd0, 8'd0, 1'b0);
         rs[i] = 1'b0;
      end
      tick(20);
      for (int i = 0; i < 2; i++) chk("drain", i, 64'(sb[i].size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
